fifo_sync_prog: RTL and testbench
=================================

Name: fifo_sync_prog

Overview:
Parametrised synchronous single-clock FIFO. Generalises the team's fixed 8-deep FIFO with:
- arbitrary (non-power-of-two) depth,
- programmable almost-full/almost-empty thresholds,
- a synchronous flush,
- an exported occupancy count.

It sits between producer and consumer blocks in the datapath and keeps the existing wr_ack/overflow/underflow status contract.

Parameters:
- DATA_W, 16, data word width in bits (>=1)
- DEPTH, 8, number of storage entries (>=2, need not be a power of two)
- AF_LEVEL, DEPTH-1, almostfull asserted when count >= AF_LEVEL and count < DEPTH (1..DEPTH-1)
- AE_LEVEL, 1, almostempty asserted when count <= AE_LEVEL and count > 0 (1..DEPTH-1)
- CNT_W, $clog2(DEPTH+1), width of count port (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of contents, sampled like rst_n but lower priority
- wr_en  in  1  write request
- data_in  in  DATA_W  write data
- rd_en  in  1  read request
- data_out  out  DATA_W  read data
- wr_ack  out  1  registered: previous-cycle write accepted
- overflow  out  1  registered: previous-cycle write rejected (full)
- underflow  out  1  registered: previous-cycle read rejected (empty)
- full  out  1  count == DEPTH (combinational from count)
- empty  out  1  count == 0
- almostfull  out  1  see AF_LEVEL
- almostempty  out  1  see AE_LEVEL
- count  out  CNT_W  current occupancy 0..DEPTH

Behaviour:
- Reset (rst_n=0 at posedge): wr_ptr=0, rd_ptr=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0.
  - Flags follow: empty=1, full=0, almostfull=0, almostempty=0.
  - Memory contents are not cleared.
- Flush (rst_n=1, flush=1): same pointer/count/status clear as reset. data_out holds its value. wr_en/rd_en are ignored that cycle.
- Write accept: wr_en && !full.
  - mem[wr_ptr] <= data_in; wr_ack <= 1.
  - wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
- Write reject: wr_en && full. overflow <= 1, wr_ack <= 0, no state change.
- No write: wr_ack <= 0, overflow <= 0.
- Read accept: rd_en && !empty.
  - data_out <= mem[rd_ptr]; 1-cycle read latency.
  - rd_ptr wraps like wr_ptr.
- Read reject: rd_en && empty. underflow <= 1; data_out holds.
- No read: underflow <= 0; data_out holds.
- Simultaneous wr_en && rd_en:
  - Empty: write only, underflow <= 1, count +1.
  - Full: read only, overflow <= 1, count -1.
  - Otherwise: both occur, count unchanged.
- count arithmetic: +1 on write-only accept, -1 on read-only accept. Never exceeds DEPTH, never goes below 0.
- Status outputs are registered one-cycle pulses. Flags are combinational from registered count, so they change in the same cycle count updates.
- Reset mid-operation: any cycle with rst_n=0 forces the reset state regardless of wr_en/rd_en/flush.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out = mem[rd_ptr] combinationally when !empty, 0 when empty.
  - rd_en accept pops the head; the next head appears in the following cycle.
  - Read latency 0; underflow rules unchanged.
- Undefined: registered 1-cycle-latency data_out as described in Behaviour.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles -> count=0, empty=1, full=0, almostempty=0, wr_ack=0, overflow=0, underflow=0, data_out=0.
2. Fill then overflow (DEPTH=8): write 0x0001..0x0008 -> wr_ack=1 each cycle after write, almostempty=1 at count=1, almostfull=1 at count=7, full=1 at count=8. Write 0x0009 -> overflow=1 next cycle, count stays 8.
3. Drain then underflow: from full, read 8 times -> data_out 0x0001..0x0008 in order, one cycle after each rd_en. Extra read -> underflow=1, data_out holds 0x0008, empty=1.
4. Simultaneous wr/rd:
   - At count=3 -> count stays 3, data_out = oldest word.
   - At count=0 -> count=1, underflow=1.
   - At count=8 -> count=7, overflow=1.
5. Wrap with DEPTH=5, AF_LEVEL=3, AE_LEVEL=2: 12 interleaved writes/reads keeping count 1..4 -> pointers wrap 4->0, data order preserved, almostfull asserted exactly at count 3..4, almostempty exactly at count 1..2.
6. Flush/reset mid-stream: at count=4 assert flush with wr_en=1 -> count=0, empty=1, no wr_ack. Next write 0xABCD then read -> data_out=0xABCD. Repeat with rst_n=0 -> same clear and data_out=0.
   - FWFT build: after the 0xABCD write, data_out=0xABCD with no rd_en.

Source files
------------

// File: rtl/fifo_sync_prog.sv
// Synchronous single-clock FIFO with arbitrary depth, programmable almost-full/empty, flush and count.
// Optional build macro FIFO_FWFT_EN selects first-word-fall-through read data instead of registered data.
module fifo_sync_prog #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              wr_ack,
    output logic              overflow,
    output logic              underflow,
    output logic              full,
    output logic              empty,
    output logic              almostfull,
    output logic              almostempty,
    output logic [CNT_W-1:0]  count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ack_q, wr_ack_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;

    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= CNT_AF) && (count_q < CNT_FULL);
    assign almostempty = (count_q <= CNT_AE) && (count_q != '0);
    assign count       = count_q;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    // Flush masks both requests, so every accept/reject term below is already flush-qualified.
    assign wr_acc = wr_en && !full && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_ack_d    = wr_acc;
        overflow_d  = wr_en && full && !flush;
        underflow_d = rd_en && empty && !flush;

        if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage has no reset; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) mem[wr_ptr_q] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem[rd_ptr_q];
`else
    logic [DATA_W-1:0] data_out_q;

    always_ff @(posedge clk) begin
        if (!rst_n)      data_out_q <= '0;
        else if (rd_acc) data_out_q <= mem[rd_ptr_q];
    end

    assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Scoreboard bench for fifo_sync_prog: a DEPTH=8 and a DEPTH=5 instance share stimulus,
// each checked against a queue-based model of the FIFO rules.
module tb_fifo_sync_prog;

    typedef struct packed {
        logic [3:0]  count;
        logic        full;
        logic        empty;
        logic        af;
        logic        ae;
        logic        ack;
        logic        ov;
        logic        un;
        logic [15:0] dout;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] data_in = '0;

    logic [15:0] dout8, dout5;
    logic        ack8, ov8, un8, full8, empty8, af8, ae8;
    logic        ack5, ov5, un5, full5, empty5, af5, ae5;
    logic [3:0]  cnt8;
    logic [2:0]  cnt5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_sync_prog #(.DATA_W(16), .DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(dout8), .wr_ack(ack8), .overflow(ov8), .underflow(un8),
        .full(full8), .empty(empty8), .almostfull(af8), .almostempty(ae8), .count(cnt8)
    );

    fifo_sync_prog #(.DATA_W(16), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2)) dut5 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(dout5), .wr_ack(ack5), .overflow(ov5), .underflow(un5),
        .full(full5), .empty(empty5), .almostfull(af5), .almostempty(ae5), .count(cnt5)
    );

    exp_t got [2];
    assign got[0] = {cnt8, full8, empty8, af8, ae8, ack8, ov8, un8, dout8};
    assign got[1] = {1'b0, cnt5, full5, empty5, af5, ae5, ack5, ov5, un5, dout5};

    // Reference model state per instance.
    int          depth_m [2] = '{8, 5};
    int          af_m    [2] = '{7, 3};
    int          ae_m    [2] = '{1, 2};
    logic [15:0] mq      [2][$];
    logic [15:0] mdout   [2] = '{16'h0, 16'h0};
    exp_t        exp_q   [2][$];
    int          cyc = 0;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL dut%0d %s at cycle %0d: got 0x%0h expected 0x%0h",
                     (k == 0) ? 8 : 5, name, cyc, act, req);
        end
    endtask

    task automatic model_step(input int k, input logic r, input logic f, input logic w,
                              input logic rd, input logic [15:0] d);
        exp_t e;
        int   n;
        logic is_full, is_empty, wa, ra;
        e = '0;
        if (!r) begin
            mq[k].delete();
            mdout[k] = 16'h0;
        end else if (f) begin
            mq[k].delete();
        end else begin
            n        = mq[k].size();
            is_full  = (n == depth_m[k]);
            is_empty = (n == 0);
            wa       = w && !is_full;
            ra       = rd && !is_empty;
            if (ra) mdout[k] = mq[k].pop_front();
            if (wa) mq[k].push_back(d);
            e.ack = wa;
            e.ov  = w && is_full;
            e.un  = rd && is_empty;
        end
        n       = mq[k].size();
        e.count = 4'(n);
        e.full  = (n == depth_m[k]);
        e.empty = (n == 0);
        e.af    = (n >= af_m[k]) && (n < depth_m[k]);
        e.ae    = (n <= ae_m[k]) && (n > 0);
`ifdef FIFO_FWFT_EN
        e.dout  = (n > 0) ? mq[k][0] : 16'h0;
`else
        e.dout  = mdout[k];
`endif
        exp_q[k].push_back(e);
    endtask

    task automatic drive(input logic r, input logic f, input logic w, input logic rd,
                         input logic [15:0] d);
        @(negedge clk);
        rst_n   = r;
        flush   = f;
        wr_en   = w;
        rd_en   = rd;
        data_in = d;
        for (int k = 0; k < 2; k++) model_step(k, r, f, w, rd, d);
    endtask

    task automatic compare(input int k, input exp_t a, input exp_t e);
        check("count",       k, 32'(a.count), 32'(e.count));
        check("full",        k, 32'(a.full),  32'(e.full));
        check("empty",       k, 32'(a.empty), 32'(e.empty));
        check("almostfull",  k, 32'(a.af),    32'(e.af));
        check("almostempty", k, 32'(a.ae),    32'(e.ae));
        check("wr_ack",      k, 32'(a.ack),   32'(e.ack));
        check("overflow",    k, 32'(a.ov),    32'(e.ov));
        check("underflow",   k, 32'(a.un),    32'(e.un));
        check("data_out",    k, 32'(a.dout),  32'(e.dout));
    endtask

    // Monitor: each edge the DUTs present a fresh output set; pop and compare.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (exp_q[k].size() > 0) compare(k, got[k], exp_q[k].pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wp, rp;
        logic r, f, w, rd;

        // Reset then idle
        drive(0, 0, 0, 0, 16'h0);
        drive(0, 0, 1, 1, 16'hFFFF);
        drive(1, 0, 0, 0, 16'h0);

        // Fill then overflow
        for (int i = 1; i <= 8; i++) drive(1, 0, 1, 0, 16'(i));
        drive(1, 0, 1, 0, 16'h0009);

        // Drain then underflow
        for (int i = 0; i < 9; i++) drive(1, 0, 0, 1, 16'h0);

        // Simultaneous read/write at count 3, 0 and full
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 16'h0020 + 16'(i));
        drive(1, 0, 1, 1, 16'h0030);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 16'h0);
        drive(1, 0, 1, 1, 16'h0040);
        for (int i = 0; i < 7; i++) drive(1, 0, 1, 0, 16'h0041 + 16'(i));
        drive(1, 0, 1, 1, 16'h0050);

        // Interleaved traffic exercising pointer wrap
        drive(1, 1, 0, 0, 16'h0);
        drive(1, 0, 1, 0, 16'h0100);
        for (int i = 0; i < 12; i++) drive(1, 0, 1, (i % 3) != 0, 16'h0101 + 16'(i));
        for (int i = 0; i < 12; i++) drive(1, 0, (i % 3) == 0, 1, 16'h0120 + 16'(i));

        // Flush mid-stream with a write request, then recover
        drive(1, 1, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, 16'h0200 + 16'(i));
        drive(1, 1, 1, 0, 16'h0299);
        drive(1, 0, 1, 0, 16'hABCD);
        drive(1, 0, 0, 0, 16'h0);
        drive(1, 0, 0, 1, 16'h0);
        drive(1, 0, 0, 0, 16'h0);

        // Reset mid-stream with requests active
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, 16'h0300 + 16'(i));
        drive(0, 1, 1, 1, 16'h0399);
        drive(1, 0, 1, 0, 16'hABCD);
        drive(1, 0, 0, 1, 16'h0);
        drive(1, 0, 0, 0, 16'h0);

        // Randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 3000; i++) begin
            wp = ((i / 150) % 2 == 0) ? 70 : 30;
            rp = 100 - wp;
            r  = ($urandom_range(0, 199) != 0);
            f  = ($urandom_range(0, 59) == 0);
            w  = ($urandom_range(0, 99) < wp);
            rd = ($urandom_range(0, 99) < rp);
            drive(r, f, w, rd, 16'($urandom));
        end

        drive(1, 0, 0, 0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("scoreboard_drained", k, 32'(exp_q[k].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
